pa_fdsu_special_pack: RTL and testbench

PA_FDSU_SPECIAL_PACK -- requirements
Module: pa_fdsu_special_pack

---
 rtl/pa_fdsu_special_pack_pkg.sv | 30 +++
 rtl/pa_fdsu_special_pack_enc.sv | 35 +++
 rtl/pa_fdsu_special_pack.sv | 74 +++++++
 tb/tb_pa_fdsu_special_pack.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pa_fdsu_special_pack_pkg.sv
// Shared FDSU special-result constants: select/sign bit indices, packed constants,
// FSM state encodings and the select one-hot check helper.
package pa_fdsu_special_pack_pkg;

   localparam int SEL_ZERO     = 1;
   localparam int SEL_INF      = 2;
   localparam int SEL_LFN      = 3;
   localparam int SEL_CNAN     = 4;
   localparam int SEL_QNAN_OP0 = 5;
   localparam int SEL_QNAN_OP1 = 6;

   localparam int SIGN_ZERO = 1;
   localparam int SIGN_INF  = 2;
   localparam int SIGN_LFN  = 3;

   localparam logic [31:0] CNAN_VALUE = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX    = 8'hFF;
   localparam logic [7:0]  EXP_LFN    = 8'hFE;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } special_state_t;

   // True when more than one of the meaningful select bits is set.
   function automatic logic sel_multi_hot(input logic [5:0] sel);
      return (sel & (sel - 6'd1)) != 6'd0;
   endfunction

endpackage

// File: rtl/pa_fdsu_special_pack_enc.sv
// Combinational special-result encoder: picks the highest-priority special case
// and packs it into an IEEE single.
module pa_fdsu_special_enc
   import pa_fdsu_special_pack_pkg::*;
(
   input  logic [7:0]  sel,
   input  logic [3:0]  sign,
   input  logic [31:0] op0_data,
   input  logic [31:0] op1_data,
   output logic [31:0] result
);

   logic unused_bits;

   // Reserved select/sign bits and NaN exponent bits never reach the result.
   assign unused_bits = ^{sel[7], sel[0], sign[0], op0_data[30:22], op1_data[30:22]};

   always_comb begin
      result = 32'h0;
      if (sel[SEL_QNAN_OP1]) begin
         result = {op1_data[31], EXP_MAX, 1'b1, op1_data[21:0]};
      end else if (sel[SEL_QNAN_OP0]) begin
         result = {op0_data[31], EXP_MAX, 1'b1, op0_data[21:0]};
      end else if (sel[SEL_CNAN]) begin
         result = CNAN_VALUE;
      end else if (sel[SEL_INF]) begin
         result = {sign[SIGN_INF], EXP_MAX, 23'h0};
      end else if (sel[SEL_ZERO]) begin
         result = {sign[SIGN_ZERO], 31'h0};
      end else if (sel[SEL_LFN]) begin
         result = {sign[SIGN_LFN], EXP_LFN, 23'h7F_FFFF};
      end
   end

endmodule

// File: rtl/pa_fdsu_special_pack.sv
// Special-result pack stage: captures bypassed div/sqrt results and holds them
// for writeback. Optional select check enabled by PA_FDSU_SPECIAL_SEL_CHK_EN.
module pa_fdsu_special_pack
   import pa_fdsu_special_pack_pkg::*;
(
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        ex1_pipe_vld,
   input  logic        ex1_srt_skip,
   input  logic [7:0]  ex1_special_sel,
   input  logic [3:0]  ex1_special_sign,
   input  logic [4:0]  ex1_fflags,
   input  logic [31:0] ex1_op0_data,
   input  logic [31:0] ex1_op1_data,
   input  logic        ex1_flush,
   input  logic        wb_special_ready,
   output logic        ex1_special_stall,
   output logic        ex2_special_vld,
   output logic [31:0] ex2_special_result,
   output logic [4:0]  ex2_special_fflags,
   output logic        special_sel_err
);

   special_state_t state;
   logic [31:0]    enc_result;
   logic           capture;

   pa_fdsu_special_enc u_enc (
      .sel      (ex1_special_sel),
      .sign     (ex1_special_sign),
      .op0_data (ex1_op0_data),
      .op1_data (ex1_op1_data),
      .result   (enc_result)
   );

   // Stall only while a held result is blocked and another skip is waiting.
   assign ex1_special_stall = (state == ST_HOLD) && !wb_special_ready
                              && ex1_pipe_vld && ex1_srt_skip;

   assign capture = ex1_pipe_vld && ex1_srt_skip && !ex1_flush && !ex1_special_stall;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state              <= ST_IDLE;
         ex2_special_vld    <= 1'b0;
         ex2_special_result <= 32'h0;
         ex2_special_fflags <= 5'h0;
      end else if (ex1_flush) begin
         state           <= ST_IDLE;
         ex2_special_vld <= 1'b0;
      end else if (capture) begin
         state              <= ST_HOLD;
         ex2_special_vld    <= 1'b1;
         ex2_special_result <= enc_result;
         ex2_special_fflags <= ex1_fflags;
      end else if (state == ST_HOLD && wb_special_ready) begin
         state           <= ST_IDLE;
         ex2_special_vld <= 1'b0;
      end
   end

`ifdef PA_FDSU_SPECIAL_SEL_CHK_EN
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         special_sel_err <= 1'b0;
      end else if (capture && sel_multi_hot(ex1_special_sel[6:1])) begin
         special_sel_err <= 1'b1;
      end
   end
`else
   assign special_sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pa_fdsu_special_pack.sv
// Directed bench for pa_fdsu_special_pack: encoder vector table plus
// backpressure, flush, select-error and asynchronous reset sequences.
module tb_pa_fdsu_special_pack;

   logic        forever_cpuclk;
   logic        cpurst_b;
   logic        ex1_pipe_vld;
   logic        ex1_srt_skip;
   logic [7:0]  ex1_special_sel;
   logic [3:0]  ex1_special_sign;
   logic [4:0]  ex1_fflags;
   logic [31:0] ex1_op0_data;
   logic [31:0] ex1_op1_data;
   logic        ex1_flush;
   logic        wb_special_ready;
   logic        ex1_special_stall;
   logic        ex2_special_vld;
   logic [31:0] ex2_special_result;
   logic [4:0]  ex2_special_fflags;
   logic        special_sel_err;

   int total;
   int bad;

`ifdef PA_FDSU_SPECIAL_SEL_CHK_EN
   localparam logic ERR_EXPECTED = 1'b1;
`else
   localparam logic ERR_EXPECTED = 1'b0;
`endif

   typedef struct {
      logic [7:0]  sel;
      logic [3:0]  sign;
      logic [31:0] op0;
      logic [31:0] op1;
      logic [4:0]  fflags;
      logic [31:0] exp_result;
   } vec_t;

   vec_t vecs[11];

   pa_fdsu_special_pack dut (
      .forever_cpuclk     (forever_cpuclk),
      .cpurst_b           (cpurst_b),
      .ex1_pipe_vld       (ex1_pipe_vld),
      .ex1_srt_skip       (ex1_srt_skip),
      .ex1_special_sel    (ex1_special_sel),
      .ex1_special_sign   (ex1_special_sign),
      .ex1_fflags         (ex1_fflags),
      .ex1_op0_data       (ex1_op0_data),
      .ex1_op1_data       (ex1_op1_data),
      .ex1_flush          (ex1_flush),
      .wb_special_ready   (wb_special_ready),
      .ex1_special_stall  (ex1_special_stall),
      .ex2_special_vld    (ex2_special_vld),
      .ex2_special_result (ex2_special_result),
      .ex2_special_fflags (ex2_special_fflags),
      .special_sel_err    (special_sel_err)
   );

   initial forever_cpuclk = 1'b0;
   always #5 forever_cpuclk = ~forever_cpuclk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drive one skip request at the negedge; it is captured at the next posedge.
   task automatic applyStimulus(input logic [7:0] sel, input logic [3:0] sign,
                                input logic [31:0] op0, input logic [31:0] op1,
                                input logic [4:0] fflags, input logic ready);
      ex1_pipe_vld     = 1'b1;
      ex1_srt_skip     = 1'b1;
      ex1_special_sel  = sel;
      ex1_special_sign = sign;
      ex1_op0_data     = op0;
      ex1_op1_data     = op1;
      ex1_fflags       = fflags;
      wb_special_ready = ready;
   endtask

   task automatic idleInputs();
      ex1_pipe_vld = 1'b0;
      ex1_srt_skip = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cpurst_b         = 1'b0;
      ex1_flush        = 1'b0;
      wb_special_ready = 1'b1;
      applyStimulus(8'h00, 4'h0, 32'h0, 32'h0, 5'h0, 1'b1);
      idleInputs();

      vecs[0]  = '{8'h04, 4'h4, 32'h0,        32'h0,        5'h00, 32'hFF80_0000};
      vecs[1]  = '{8'h20, 4'h0, 32'h7F80_0001, 32'h0,       5'h10, 32'h7FC0_0001};
      vecs[2]  = '{8'h60, 4'h0, 32'h7F80_0001, 32'hFF81_2345, 5'h10, 32'hFFC1_2345};
      vecs[3]  = '{8'h10, 4'h0, 32'h0,        32'h0,        5'h10, 32'h7FC0_0000};
      vecs[4]  = '{8'h02, 4'h2, 32'h0,        32'h0,        5'h08, 32'h8000_0000};
      vecs[5]  = '{8'h08, 4'h8, 32'h0,        32'h0,        5'h05, 32'hFF7F_FFFF};
      vecs[6]  = '{8'h08, 4'h0, 32'h0,        32'h0,        5'h05, 32'h7F7F_FFFF};
      vecs[7]  = '{8'h81, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 5'h00, 32'h0000_0000};
      vecs[8]  = '{8'h14, 4'h4, 32'h0,        32'h0,        5'h10, 32'h7FC0_0000};
      vecs[9]  = '{8'h04, 4'h0, 32'h0,        32'h0,        5'h00, 32'h7F80_0000};
      vecs[10] = '{8'h20, 4'h0, 32'hFF80_0005, 32'h0,       5'h10, 32'hFFC0_0005};

      #12;
      checkOutput("reset_vld",    {31'h0, ex2_special_vld},   32'h0);
      checkOutput("reset_result", ex2_special_result,         32'h0);
      checkOutput("reset_fflags", {27'h0, ex2_special_fflags}, 32'h0);
      checkOutput("reset_err",    {31'h0, special_sel_err},   32'h0);
      checkOutput("reset_stall",  {31'h0, ex1_special_stall}, 32'h0);
      @(negedge forever_cpuclk);
      cpurst_b = 1'b1;

      // Table: capture, one-cycle latency, retire with ready=1.
      for (int i = 0; i < 11; i++) begin
         @(negedge forever_cpuclk);
         applyStimulus(vecs[i].sel, vecs[i].sign, vecs[i].op0, vecs[i].op1,
                       vecs[i].fflags, 1'b1);
         @(negedge forever_cpuclk);
         idleInputs();
         checkOutput($sformatf("vec%0d_vld", i), {31'h0, ex2_special_vld}, 32'h1);
         checkOutput($sformatf("vec%0d_result", i), ex2_special_result, vecs[i].exp_result);
         checkOutput($sformatf("vec%0d_fflags", i), {27'h0, ex2_special_fflags},
                     {27'h0, vecs[i].fflags});
         @(negedge forever_cpuclk);
         checkOutput($sformatf("vec%0d_retired", i), {31'h0, ex2_special_vld}, 32'h0);
      end

      // Backpressure: first result held while a second skip waits.
      @(negedge forever_cpuclk);
      applyStimulus(8'h04, 4'h4, 32'h0, 32'h0, 5'h00, 1'b0);
      @(negedge forever_cpuclk);
      applyStimulus(8'h02, 4'h2, 32'h0, 32'h0, 5'h08, 1'b0);
      #1;
      for (int c = 0; c < 3; c++) begin
         checkOutput($sformatf("bp_stall%0d", c), {31'h0, ex1_special_stall}, 32'h1);
         checkOutput($sformatf("bp_vld%0d", c), {31'h0, ex2_special_vld}, 32'h1);
         checkOutput($sformatf("bp_result%0d", c), ex2_special_result, 32'hFF80_0000);
         @(negedge forever_cpuclk);
         #1;
      end
      wb_special_ready = 1'b1;
      #1;
      checkOutput("bp_stall_release", {31'h0, ex1_special_stall}, 32'h0);
      @(negedge forever_cpuclk);
      idleInputs();
      checkOutput("bp_second_vld",    {31'h0, ex2_special_vld}, 32'h1);
      checkOutput("bp_second_result", ex2_special_result, 32'h8000_0000);
      checkOutput("bp_second_fflags", {27'h0, ex2_special_fflags}, 32'h08);
      @(negedge forever_cpuclk);
      checkOutput("bp_drained", {31'h0, ex2_special_vld}, 32'h0);

      // Flush while holding with ready low, then flush alongside a capture.
      applyStimulus(8'h10, 4'h0, 32'h0, 32'h0, 5'h10, 1'b0);
      @(negedge forever_cpuclk);
      idleInputs();
      checkOutput("fl_held", {31'h0, ex2_special_vld}, 32'h1);
      ex1_flush = 1'b1;
      @(negedge forever_cpuclk);
      ex1_flush = 1'b0;
      checkOutput("fl_dropped", {31'h0, ex2_special_vld}, 32'h0);
      applyStimulus(8'h04, 4'h4, 32'h0, 32'h0, 5'h00, 1'b1);
      ex1_flush = 1'b1;
      @(negedge forever_cpuclk);
      ex1_flush = 1'b0;
      idleInputs();
      checkOutput("fl_no_capture", {31'h0, ex2_special_vld}, 32'h0);

      // Non-one-hot select: inf wins, error flag sticky when the check exists.
      @(negedge forever_cpuclk);
      applyStimulus(8'h0C, 4'hC, 32'h0, 32'h0, 5'h00, 1'b1);
      @(negedge forever_cpuclk);
      applyStimulus(8'h04, 4'h0, 32'h0, 32'h0, 5'h00, 1'b1);
      checkOutput("err_result", ex2_special_result, 32'hFF80_0000);
      checkOutput("err_flag",   {31'h0, special_sel_err}, {31'h0, ERR_EXPECTED});
      @(negedge forever_cpuclk);
      idleInputs();
      checkOutput("err_onehot_result", ex2_special_result, 32'h7F80_0000);
      checkOutput("err_sticky", {31'h0, special_sel_err}, {31'h0, ERR_EXPECTED});

      // Asynchronous reset in HOLD with a pending skip.
      @(negedge forever_cpuclk);
      applyStimulus(8'h08, 4'h8, 32'h0, 32'h0, 5'h05, 1'b0);
      @(negedge forever_cpuclk);
      checkOutput("rst_pre_vld",   {31'h0, ex2_special_vld},   32'h1);
      checkOutput("rst_pre_stall", {31'h0, ex1_special_stall}, 32'h1);
      #2;
      cpurst_b = 1'b0;
      #1;
      checkOutput("rst_async_vld",    {31'h0, ex2_special_vld},    32'h0);
      checkOutput("rst_async_result", ex2_special_result,          32'h0);
      checkOutput("rst_async_fflags", {27'h0, ex2_special_fflags}, 32'h0);
      checkOutput("rst_async_err",    {31'h0, special_sel_err},    32'h0);
      checkOutput("rst_async_stall",  {31'h0, ex1_special_stall},  32'h0);
      idleInputs();
      @(negedge forever_cpuclk);
      cpurst_b = 1'b1;
      @(negedge forever_cpuclk);
      checkOutput("rst_no_retire", {31'h0, ex2_special_vld}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
